// File: rtl/debug_command_unit.sv
// debug_command_unit: decodes host command bytes, drives core step/run/soft-reset,
// and streams a snapshot of the core debug vector into the UART transmit FIFO.
module debug_command_unit #(
   parameter int unsigned DUMP_BYTES     = 220,
   parameter logic [7:0]  CMD_BREAK      = 8'h30,
   parameter logic [7:0]  CMD_ONE_STEP   = 8'h31,
   parameter logic [7:0]  CMD_RUN_ALL    = 8'h32,
   parameter logic [7:0]  CMD_SOFT_RESET = 8'h33,
   parameter logic [7:0]  CMD_DUMP       = 8'h34,
   parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [7:0]              r_data,
   input  logic                    rx_ready,
   output logic                    rd_uart,
   output logic [7:0]              tx_data,
   output logic                    wr_uart,
   input  logic                    tx_full,
   input  logic [8*DUMP_BYTES-1:0] dump_data,
   output logic                    cpu_step,
   output logic                    cpu_run,
   input  logic                    cpu_halted,
   output logic                    cpu_soft_reset,
   output logic                    busy,
   output logic [3:0]              current_state
);
   localparam int CW = $clog2(DUMP_BYTES + 1);
   localparam logic [CW-1:0] LAST = CW'(DUMP_BYTES);
   typedef enum logic [3:0] {
      IDLE = 4'd0, DECODE = 4'd1, STEP = 4'd2, RUN = 4'd3, SRESET = 4'd4,
      LOAD = 4'd5, SEND = 4'd6, GAP = 4'd7, NAK = 4'd8
   } state_t;
   state_t state, next;
   logic [7:0] cmd;
   logic [8*DUMP_BYTES-1:0] shift;
   logic [CW-1:0] count;
   logic is_break;
   assign is_break = rx_ready && r_data == CMD_BREAK;
   always_ff @(negedge clock or negedge reset)
      if (!reset) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      case (state)
         IDLE:         next = rx_ready ? DECODE : IDLE;
         DECODE:       next = cmd == CMD_ONE_STEP   ? STEP   :
                              cmd == CMD_RUN_ALL    ? RUN    :
                              cmd == CMD_SOFT_RESET ? SRESET :
                              cmd == CMD_DUMP       ? LOAD   : NAK;
         STEP, SRESET: next = LOAD;
         // halt is checked first so a byte arriving with it stays queued
         RUN:          next = (cpu_halted || is_break) ? LOAD : RUN;
         LOAD:         next = SEND;
         SEND:         next = tx_full ? SEND : GAP;
         GAP:          next = count == LAST ? IDLE : SEND;
         NAK:          next = tx_full ? NAK : IDLE;
         default:      next = IDLE;
      endcase
   end
   always_ff @(negedge clock or negedge reset)
      if (!reset) begin
         cmd   <= '0;
         shift <= '0;
         count <= '0;
      end else begin
         if (state == IDLE && rx_ready) cmd <= r_data;
         if (state == LOAD) begin
            shift <= dump_data;
            count <= '0;
         end else if (state == SEND && !tx_full) begin
            shift <= shift >> 8;
            count <= count + 1'b1;
         end
      end
   always_comb begin
      rd_uart        = reset && rx_ready && (state == IDLE || (state == RUN && !cpu_halted));
      wr_uart        = !tx_full && (state == SEND || state == NAK);
      tx_data        = !wr_uart ? 8'h00 : state == NAK ? NAK_BYTE : shift[7:0];
      cpu_step       = state == STEP;
      cpu_run        = state == RUN && !cpu_halted && !is_break;
      cpu_soft_reset = state == SRESET;
      busy           = state != IDLE;
      current_state  = state;
   end
endmodule

// File: tb/tb_debug_command_unit.sv
// tb_debug_command_unit: random command traffic against a transaction-level model of
// the debug unit, fed from a modelled receive FIFO and a randomly stalling transmit FIFO.
module tb_debug_command_unit;
   localparam int DB = 4;
   localparam logic [7:0] NAK_B = 8'h15;
   logic clock = 0, reset = 1;
   logic [7:0] r_data, tx_data;
   logic rx_ready, rd_uart, wr_uart, cpu_step, cpu_run, cpu_soft_reset, busy;
   logic tx_full = 0, cpu_halted = 0;
   logic [8*DB-1:0] dump_data = '0;
   logic [3:0] current_state;
   logic [17:0] outs;
   logic [7:0] fifo [256];
   int wp = 0, rp = 0;
   bit pop_pend = 0, stall_en = 0;
   int checks = 0, failures = 0, cyc = 0, n_step = 0, n_srst = 0, n_run = 0, step_cyc = 0;
   logic [7:0] got_tx[$], got_pop[$];
   int wr_cyc[$], pop_cyc[$];

   debug_command_unit #(.DUMP_BYTES(DB)) dut (
      .clock(clock), .reset(reset), .r_data(r_data), .rx_ready(rx_ready), .rd_uart(rd_uart),
      .tx_data(tx_data), .wr_uart(wr_uart), .tx_full(tx_full), .dump_data(dump_data),
      .cpu_step(cpu_step), .cpu_run(cpu_run), .cpu_halted(cpu_halted),
      .cpu_soft_reset(cpu_soft_reset), .busy(busy), .current_state(current_state)
   );

   always #5 clock = ~clock;
   assign rx_ready = wp != rp;
   assign r_data = fifo[rp[7:0]];
   assign outs = {rd_uart, wr_uart, cpu_step, cpu_run, cpu_soft_reset, busy, tx_data, current_state};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      fifo[wp[7:0]] = b;
      wp++;
   endtask

   // DUT state moves on the falling edge; stimulus changes just after it
   task automatic tick();
      @(negedge clock);
      #2;
   endtask

   task automatic clear();
      got_tx.delete(); got_pop.delete(); wr_cyc.delete(); pop_cyc.delete();
      n_step = 0; n_srst = 0; n_run = 0;
   endtask

   // outputs are observed mid-cycle, half a period before the DUT acts on them
   always @(posedge clock) begin
      pop_pend = reset && rd_uart;
      if (reset) begin
         cyc++;
         if (rd_uart) begin got_pop.push_back(r_data); pop_cyc.push_back(cyc); end
         if (wr_uart) begin
            check("wr_while_full", 32'(tx_full), 32'd0);
            got_tx.push_back(tx_data);
            wr_cyc.push_back(cyc);
         end
         if (cpu_step) begin n_step++; step_cyc = cyc; end
         if (cpu_soft_reset) n_srst++;
         if (cpu_run) n_run++;
      end
   end

   always @(negedge clock) begin
      #1;
      if (pop_pend) rp++;
   end

   // mode 0: plain, 1: RUN ended by halt (with a BREAK byte arriving alongside),
   // 2: RUN ended by noise byte then BREAK, 3: 10-cycle tx_full stall after first byte
   task automatic run_cmd(input logic [7:0] c, input int mode, input int n);
      logic [7:0] exp[$];
      logic [8*DB-1:0] snap;
      int k, hold;
      bit seen, done, scrambled;
      k = 0; hold = 0; seen = 0; done = 0; scrambled = 0;
      clear();
      dump_data = 32'($urandom);
      snap = dump_data;
      if (c >= 8'h31 && c <= 8'h34) for (int i = 0; i < DB; i++) exp.push_back(snap[8*i +: 8]);
      else exp.push_back(NAK_B);
      if (mode == 1) exp.push_back(NAK_B);
      push(c);
      for (int t = 0; t < 600 && !done; t++) begin
         tick();
         if (busy) seen = 1;
         if (got_tx.size() > 0 && !scrambled) begin dump_data = 32'($urandom); scrambled = 1; end
         if (mode == 3 && got_tx.size() > 0 && hold < 10) begin tx_full = 1; hold++; end
         else tx_full = stall_en && $urandom_range(0, 2) == 0;
         if (cpu_run) begin
            k++;
            if (mode == 1 && k == n) begin
               cpu_halted = 1;
               push(8'h30);
               #1 check("run_drop", 32'(cpu_run), 32'd0);
            end
            if (mode == 2 && k == n) push(8'h41);
            if (mode == 2 && k == n + 3) push(8'h30);
         end
         done = seen && !busy && !rx_ready;
      end
      cpu_halted = 0;
      tx_full = 0;
      check("done_idle", 32'(busy), 32'd0);
      check("tx_count", got_tx.size(), exp.size());
      foreach (exp[i]) if (i < got_tx.size()) check("tx_byte", 32'(got_tx[i]), 32'(exp[i]));
      check("step_pulses", n_step, 32'(c == 8'h31));
      check("srst_pulses", n_srst, 32'(c == 8'h33));
      check("run_cycles", n_run, mode == 1 ? n - 1 : mode == 2 ? n + 2 : 0);
      check("pops", got_pop.size(), mode == 2 ? 3 : mode == 1 ? 2 : 1);
      if (got_pop.size() > 0) check("cmd_pop", 32'(got_pop[0]), 32'(c));
      if (mode == 2 && got_pop.size() == 3) begin
         check("noise_pop", 32'(got_pop[1]), 32'h41);
         check("break_pop", 32'(got_pop[2]), 32'h30);
      end
   endtask

   initial begin
      int r;
      logic [7:0] c;
      #1 reset = 0;
      #1 check("reset_state", 32'(outs), 32'd0);
      repeat (3) tick();
      reset = 1;
      tick();
      run_cmd(8'h31, 0, 0);
      if (pop_cyc.size() > 0) check("step_latency", step_cyc - pop_cyc[0], 2);
      if (wr_cyc.size() == DB) begin
         check("first_wr_latency", wr_cyc[0] - step_cyc, 2);
         for (int i = 1; i < DB; i++) check("wr_spacing", wr_cyc[i] - wr_cyc[i-1], 2);
      end
      run_cmd(8'h32, 1, 21);
      run_cmd(8'h32, 2, 5);
      run_cmd(8'h7A, 0, 0);
      run_cmd(8'h34, 3, 0);
      run_cmd(8'h30, 0, 0);
      run_cmd(8'h33, 0, 0);
      clear();
      push(8'h34);
      for (int t = 0; t < 100 && got_tx.size() < 2; t++) tick();
      check("wait_dump2", got_tx.size(), 2);
      reset = 0;
      #1 check("reset_mid_dump", 32'(outs), 32'd0);
      repeat (2) tick();
      reset = 1;
      run_cmd(8'h31, 0, 0);
      clear();
      push(8'h32);
      for (int t = 0; t < 50 && !cpu_run; t++) tick();
      check("wait_run", 32'(cpu_run), 32'd1);
      repeat (3) tick();
      reset = 0;
      #1 check("reset_mid_run", 32'(outs), 32'd0);
      repeat (2) tick();
      reset = 1;
      run_cmd(8'h34, 0, 0);
      for (int i = 0; i < 25; i++) begin
         r = $urandom_range(0, 5);
         stall_en = $urandom_range(0, 1) == 1;
         if (r == 5) begin
            c = 8'($urandom);
            if (c >= 8'h30 && c <= 8'h34) c = c ^ 8'h80;
            run_cmd(c, 0, 0);
         end else if (r == 2) run_cmd(8'h32, $urandom_range(1, 2), $urandom_range(2, 15));
         else run_cmd(8'h30 + 8'(r), 0, 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/debug_command_unit.md
# debug_command_unit

Parametrised debug command unit between the UART receiver/transmitter pair and the MIPS core. It decodes single-byte host commands (step, run, break, soft reset, dump), drives the core's step/run/soft-reset controls, and snapshots a DUMP_BYTES-wide debug vector. It then streams that vector byte-by-byte into the UART transmit FIFO with back-pressure. It replaces fixed-width, single-shot response handling with a counted serialiser, run-until-halt with break, and a NAK response for unknown commands.

## Interface
- DUMP_BYTES, 220, number of bytes in the dump vector (≥1)
- CMD_BREAK, 8'h30, stop a free run
- CMD_ONE_STEP, 8'h31, single-step the core, then dump
- CMD_RUN_ALL, 8'h32, run until halt or break, then dump
- CMD_SOFT_RESET, 8'h33, pulse core soft reset, then dump
- CMD_DUMP, 8'h34, dump only
- NAK_BYTE, 8'h15, reply byte for an unknown command
---
- clock  in  1  system clock; all registers update on the falling edge
- reset  in  1  asynchronous, active-low reset
- r_data  in  8  byte from the UART receive FIFO
- rx_ready  in  1  receive FIFO not empty
- rd_uart  out  1  one-cycle pop of the receive FIFO
- tx_data  out  8  byte to the UART transmit FIFO
- wr_uart  out  1  one-cycle push to the transmit FIFO
- tx_full  in  1  transmit FIFO full
- dump_data  in  8*DUMP_BYTES  core debug vector; byte k = dump_data[8k+7:8k]
- cpu_step  out  1  one-cycle step pulse
- cpu_run  out  1  level; core free-runs while high
- cpu_halted  in  1  core reached its halt instruction
- cpu_soft_reset  out  1  one-cycle core reset pulse
- busy  out  1  high in every state except IDLE
- current_state  out  4  state encoding, for debug LEDs

## Operation
- States: IDLE=0, DECODE=1, STEP=2, RUN=3, SRESET=4, LOAD=5, SEND=6, GAP=7, NAK=8.
- IDLE: when rx_ready=1, latch r_data into cmd, pulse rd_uart, and go to DECODE. Otherwise hold.
- DECODE: route on cmd.
  - ONE_STEP→STEP; RUN_ALL→RUN; SOFT_RESET→SRESET; DUMP→LOAD.
  - CMD_BREAK received in IDLE, and any other value, →NAK.
- STEP: cpu_step=1 for this cycle only, then →LOAD.
- RUN: cpu_run=1 while in RUN.
  - If cpu_halted=1, clear cpu_run and go →LOAD.
  - Otherwise, if rx_ready=1, pop the byte (rd_uart pulse). If it equals CMD_BREAK, clear cpu_run and go →LOAD; any other byte is discarded and RUN continues.
  - If cpu_halted and rx_ready are both high in the same cycle, halt wins and the byte is not popped.
- SRESET: cpu_soft_reset=1 for one cycle, then →LOAD.
- LOAD: copy dump_data into the internal shift register, set count=0, then →SEND.
- SEND: when tx_full=0, present tx_data = shift[7:0] and pulse wr_uart; then shift right 8 bits, increment count, and go →GAP. When tx_full=1, hold with no write.
- GAP: idle cycle so tx_full can update. If count==DUMP_BYTES go →IDLE, else →SEND.
- NAK: when tx_full=0, pulse wr_uart with tx_data=NAK_BYTE, then →IDLE.
- count width is $clog2(DUMP_BYTES+1); count never wraps.
- Received bytes are never popped outside IDLE and RUN; they remain queued in the receive FIFO.
- dump_data changes after LOAD do not affect the bytes being sent.

## Timing
- Reset values: rd_uart, wr_uart, cpu_step, cpu_run, cpu_soft_reset, busy = 0; tx_data=0; current_state=IDLE; count=0; shift=0.
- Reset asserted mid-operation aborts immediately and cpu_run drops asynchronously. Partial dumps are not resumed.
- ONE_STEP latency: rx_ready seen → cpu_step is 2 cycles (IDLE→DECODE→STEP). First wr_uart follows 2 cycles after cpu_step (LOAD, SEND), assuming tx_full=0.
- Dump throughput: one byte per 2 cycles at best. A full dump takes 2·DUMP_BYTES cycles plus stall cycles.
- Pulse outputs are high for exactly one cycle per event.
- tx_data is valid only in cycles where wr_uart=1.

## Test plan
- DUMP_BYTES=4, dump_data=32'hDDCCBBAA, send 8'h31 → one cpu_step pulse, then wr_uart bytes AA,BB,CC,DD spaced 2 cycles apart, then IDLE with busy=0.
- Send 8'h32, hold cpu_halted=0 for 20 cycles, then raise it → cpu_run high for those 20+ cycles, drops on the halt cycle, and a 4-byte dump follows.
- Send 8'h32, then 8'h41, then 8'h30 while running → 8'h41 is popped and ignored, 8'h30 clears cpu_run, and the dump follows.
- Send 8'h7A → exactly one wr_uart with tx_data=8'h15, no core-control pulses, return to IDLE.
- Send 8'h34 with tx_full high for 10 cycles after the first byte → no writes during the stall, bytes remain in order with none lost or duplicated, 4 writes in total.
- Assert reset low mid-dump (after 2 bytes) and mid-RUN → all outputs return to reset values within the same cycle; the next command works normally.
